// File: rtl/afe_spi_shifter_pkg.sv
// Shared constants, state encoding and divider math for the AFE SPI shifter.
// Status layout: [31] busy, [30] overrun, [26:24] last channel, [WORD_WIDTH-1:0] last word.
package afe_spi_shifter_pkg;

  localparam int BUSY_BIT    = 31;
  localparam int OVERRUN_BIT = 30;
  localparam int CHSEL_LSB   = 24;
  localparam int CHSEL_W     = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLK_LO,
    ST_CLK_HI,
    ST_LE_GAP,
    ST_LE_HI
  } state_e;

  // ceil(sys / (2*spi)): the SPI clock never exceeds its rated frequency
  function automatic int half_div(input longint sys_rate, input longint spi_rate);
    return int'((sys_rate + 2 * spi_rate - 1) / (2 * spi_rate));
  endfunction

endpackage

// File: rtl/afe_spi_shifter_tick_gen.sv
// Half-period divider: one-cycle tick every HALF_DIV cycles, phase reset by restart_i.
module afe_spi_tick_gen #(
  parameter int HALF_DIV = 50
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic restart_i,
  output logic tick_o
);

  localparam int CW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(HALF_DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                       cnt_q <= '0;
    else if (restart_i || cnt_q == LAST) cnt_q <= '0;
    else                                cnt_q <= cnt_q + 1'b1;
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/afe_spi_shifter.sv
// Serial loader for the AFE attenuators: shifts a CSR word MSB-first out of one of
// CHANNEL_COUNT 3-wire SPI ports, then pulses that port's latch enable.
module afe_spi_shifter
  import afe_spi_shifter_pkg::*;
#(
  parameter int SYSCLK_RATE   = 99999001,
  parameter int SPI_CLK_RATE  = 1000000,
  parameter int CHANNEL_COUNT = 2,
  parameter int WORD_WIDTH    = 16
) (
  input  logic                     sysClk,
  input  logic                     sysReset_n,
  input  logic                     csrStrobe,
  input  logic [31:0]              GPIO_OUT,
  output logic [31:0]              status,
  output logic [CHANNEL_COUNT-1:0] AFE_SPI_CLK,
  output logic [CHANNEL_COUNT-1:0] AFE_SPI_SDI,
  output logic [CHANNEL_COUNT-1:0] AFE_SPI_LE
);

  localparam int HALF_DIV = half_div(longint'(SYSCLK_RATE), longint'(SPI_CLK_RATE));
  localparam int BW       = $clog2(WORD_WIDTH + 1);

  generate
    if (HALF_DIV < 1) begin : g_bad_div
      $error("afe_spi_shifter: HALF_DIV must be at least 1");
    end
    if (CHANNEL_COUNT < 1 || CHANNEL_COUNT > 8 || WORD_WIDTH < 1 || WORD_WIDTH > 24) begin : g_bad_cfg
      $error("afe_spi_shifter: CHANNEL_COUNT or WORD_WIDTH out of range");
    end
  endgenerate

  state_e                   state_q;
  logic [WORD_WIDTH-1:0]    sh_q, sh_d, word_q, new_word;
  logic [BW-1:0]            bits_q;
  logic [CHSEL_W-1:0]       ch_q, new_ch;
  logic                     busy_q, ovr_q;
  logic [CHANNEL_COUNT-1:0] clk_q, sdi_q, le_q, new_mask, ch_mask;
  logic                     accept, tick;
  logic                     unused_gpio;

  assign new_word    = GPIO_OUT[WORD_WIDTH-1:0];
  assign new_ch      = GPIO_OUT[CHSEL_LSB +: CHSEL_W];
  assign unused_gpio = ^GPIO_OUT;
  assign accept      = csrStrobe && (state_q == ST_IDLE);
  assign sh_d        = sh_q << 1;

  // Out-of-range selects match no bit, so the transaction runs with every pin parked
  always_comb begin
    new_mask = '0;
    ch_mask  = '0;
    for (int i = 0; i < CHANNEL_COUNT; i++) begin
      new_mask[i] = (new_ch == CHSEL_W'(i));
      ch_mask[i]  = (ch_q == CHSEL_W'(i));
    end
  end

  afe_spi_tick_gen #(.HALF_DIV(HALF_DIV)) u_tick (
    .clk_i     (sysClk),
    .rst_n_i   (sysReset_n),
    .restart_i (accept),
    .tick_o    (tick)
  );

  always_ff @(posedge sysClk or negedge sysReset_n) begin
    if (!sysReset_n) begin
      state_q <= ST_IDLE;
      sh_q    <= '0;
      word_q  <= '0;
      bits_q  <= '0;
      ch_q    <= '0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
      clk_q   <= '0;
      sdi_q   <= '0;
      le_q    <= '0;
    end else begin
      if (csrStrobe && state_q != ST_IDLE) ovr_q <= 1'b1;
      unique case (state_q)
        ST_IDLE: if (csrStrobe) begin
          state_q <= ST_CLK_LO;
          sh_q    <= new_word;
          word_q  <= new_word;
          ch_q    <= new_ch;
          bits_q  <= BW'(WORD_WIDTH);
          busy_q  <= 1'b1;
          ovr_q   <= 1'b0;
          sdi_q   <= new_mask & {CHANNEL_COUNT{new_word[WORD_WIDTH-1]}};
        end
        ST_CLK_LO: if (tick) begin
          state_q <= ST_CLK_HI;
          clk_q   <= ch_mask;
        end
        // SDI changes on the falling edge so it is stable a full period around each rise
        ST_CLK_HI: if (tick) begin
          clk_q  <= '0;
          sh_q   <= sh_d;
          bits_q <= bits_q - 1'b1;
          if (bits_q == BW'(1)) begin
            state_q <= ST_LE_GAP;
            sdi_q   <= '0;
          end else begin
            state_q <= ST_CLK_LO;
            sdi_q   <= ch_mask & {CHANNEL_COUNT{sh_d[WORD_WIDTH-1]}};
          end
        end
        ST_LE_GAP: if (tick) begin
          state_q <= ST_LE_HI;
          le_q    <= ch_mask;
        end
        ST_LE_HI: if (tick) begin
          state_q <= ST_IDLE;
          le_q    <= '0;
          busy_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    status                        = '0;
    status[BUSY_BIT]              = busy_q;
    status[OVERRUN_BIT]           = ovr_q;
    status[CHSEL_LSB +: CHSEL_W]  = ch_q;
    status[WORD_WIDTH-1:0]        = word_q;
  end

  assign AFE_SPI_CLK = clk_q;
  assign AFE_SPI_SDI = sdi_q;
  assign AFE_SPI_LE  = le_q;

endmodule
